// File: rtl/sixteen_bit_serial_subtractor_if.sv
// Operand/result bundle for the digit-serial subtractor.
// The master side issues start and operands; the slave side returns status and results.
interface sixteen_bit_serial_subtractor_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             bin;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             overflow;
    logic             borrow_out;

    modport master (
        output start, bin, a, b,
        input  busy, done, result, overflow, borrow_out
    );

    modport slave (
        input  start, bin, a, b,
        output busy, done, result, overflow, borrow_out
    );
endinterface

// File: rtl/sixteen_bit_serial_subtractor.sv
// Digit-serial subtractor that computes a - b - bin, DIGIT bits per cycle, LSB first.
// Results publish only on entry to DONE and hold until the next DONE or reset.
module sixteen_bit_serial_subtractor #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    sixteen_bit_serial_subtractor_if.slave bus
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                 state, state_nxt;
    logic [WIDTH-1:0]       a_sh, b_sh, res_q;
    logic [WIDTH-DIGIT-1:0] acc;
    logic [WIDTH-1:0]       res_fin;
    logic [DIGIT:0]         step;
    logic [CW-1:0]          cnt;
    logic                   brw, a_msb, b_msb, ovf_q, bout_q;
    logic                   last, accept;

    // Top bit of the widened difference is the borrow out of this digit.
    assign step    = {1'b0, a_sh[DIGIT-1:0]} - {1'b0, b_sh[DIGIT-1:0]}
                   - {{DIGIT{1'b0}}, brw};
    assign res_fin = {step[DIGIT-1:0], acc};
    assign last    = (cnt == CW'(N - 1));
    assign accept  = bus.start && (state == IDLE || state == DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (last)      state_nxt = DONE;
            DONE:    state_nxt = bus.start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            acc    <= '0;
            brw    <= 1'b0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            cnt    <= '0;
            res_q  <= '0;
            ovf_q  <= 1'b0;
            bout_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                a_sh  <= bus.a;
                b_sh  <= bus.b;
                brw   <= bus.bin;
                a_msb <= bus.a[WIDTH-1];
                b_msb <= bus.b[WIDTH-1];
                cnt   <= '0;
            end else if (state == RUN) begin
                a_sh <= a_sh >> DIGIT;
                b_sh <= b_sh >> DIGIT;
                brw  <= step[DIGIT];
                acc  <= res_fin[WIDTH-1:DIGIT];
                cnt  <= cnt + CW'(1);
                if (last) begin
                    res_q  <= res_fin;
                    ovf_q  <= (a_msb != b_msb) && (res_fin[WIDTH-1] != a_msb);
                    bout_q <= step[DIGIT];
                end
            end
        end
    end

    assign bus.busy       = (state == RUN);
    assign bus.done       = (state == DONE);
    assign bus.result     = res_q;
    assign bus.overflow   = ovf_q;
    assign bus.borrow_out = bout_q;
endmodule

// File: tb/tb_sixteen_bit_serial_subtractor.sv
// Directed-vector bench for the digit-serial subtractor: arithmetic corners,
// back-to-back handshake and mid-run reset.
module tb_sixteen_bit_serial_subtractor;
    logic        clk = 1'b0;
    logic        rst;
    int          vec_cnt  = 0;
    int          miss_cnt = 0;
    logic [15:0] last_res;

    sixteen_bit_serial_subtractor_if #(.WIDTH(16)) sub_if ();

    sixteen_bit_serial_subtractor #(.WIDTH(16), .DIGIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sub_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic bin,
                          input logic [15:0] er, input logic eo, input logic eb);
        int n;
        sub_if.a     = a;
        sub_if.b     = b;
        sub_if.bin   = bin;
        sub_if.start = 1'b1;
        tick;
        sub_if.start = 1'b0;
        sub_if.a     = ~a;
        sub_if.b     = ~b;
        sub_if.bin   = ~bin;
        chk("busy_on", sub_if.busy, 1);
        chk("res_hold", sub_if.result, last_res);
        n = 0;
        while (sub_if.done !== 1'b1 && n < 12) begin
            tick;
            n++;
        end
        chk("latency", n, 4);
        chk("result", sub_if.result, er);
        chk("overflow", sub_if.overflow, eo);
        chk("borrow", sub_if.borrow_out, eb);
        chk("busy_off", sub_if.busy, 0);
        last_res = er;
        tick;
        chk("done_pulse", sub_if.done, 0);
        chk("res_keep", sub_if.result, er);
    endtask

    initial begin
        rst          = 1'b1;
        sub_if.start = 1'b0;
        sub_if.a     = '0;
        sub_if.b     = '0;
        sub_if.bin   = 1'b0;
        tick;
        tick;
        chk("rst_busy", sub_if.busy, 0);
        chk("rst_done", sub_if.done, 0);
        chk("rst_res", sub_if.result, 0);
        chk("rst_ovf", sub_if.overflow, 0);
        chk("rst_brw", sub_if.borrow_out, 0);
        rst      = 1'b0;
        last_res = 16'h0000;
        tick;

        run_op(16'd15,    16'd12,    1'b0, 16'd3,     1'b0, 1'b0);
        run_op(16'd12,    16'd15,    1'b0, 16'hFFFD,  1'b0, 1'b1);
        run_op(16'd10,    16'd2,     1'b1, 16'd7,     1'b0, 1'b0);
        run_op(16'h8000,  16'h0001,  1'b0, 16'h7FFF,  1'b1, 1'b0);
        run_op(16'h7FFF,  16'hFFFF,  1'b0, 16'h8000,  1'b1, 1'b1);
        run_op(16'h0000,  16'h0000,  1'b1, 16'hFFFF,  1'b0, 1'b1);

        // start held for 12 edges; accepts land on edges 0, 5, 10
        sub_if.start = 1'b1;
        sub_if.bin   = 1'b0;
        for (int i = 0; i < 12; i++) begin
            sub_if.a = (i % 5 == 0) ? 16'd100 : 16'h1234;
            sub_if.b = (i % 5 == 0) ? 16'd1   : 16'h0777;
            tick;
            chk("hs_done", sub_if.done, (i % 5 == 4) ? 1 : 0);
            chk("hs_busy", sub_if.busy, (i % 5 == 4) ? 0 : 1);
            if (i % 5 == 4) chk("hs_res", sub_if.result, 16'd99);
        end
        sub_if.start = 1'b0;
        sub_if.a     = 16'h4321;
        tick;
        tick;
        tick;
        chk("hs_done3", sub_if.done, 1);
        chk("hs_res3", sub_if.result, 16'd99);
        tick;
        chk("hs_idle", sub_if.busy | sub_if.done, 0);
        last_res = 16'd99;

        // reset on the second RUN edge
        sub_if.a     = 16'd50;
        sub_if.b     = 16'd8;
        sub_if.start = 1'b1;
        tick;
        sub_if.start = 1'b0;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("mrst_busy", sub_if.busy, 0);
        chk("mrst_done", sub_if.done, 0);
        chk("mrst_res", sub_if.result, 0);
        for (int i = 0; i < 6; i++) begin
            tick;
            chk("mrst_nodone", sub_if.done, 0);
        end
        last_res = 16'h0000;
        run_op(16'd50, 16'd8, 1'b0, 16'd42, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end
endmodule
